// File: rtl/alu.sv
// 32-bit, eight-function ALU feeding a single result register (execute stage).
// One cycle of latency, one operation per cycle, no flags and no handshake.
module alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  Operation,
    output logic [31:0] Output
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [31:0] result_d;
    logic [31:0] result_q;
    logic        lt_signed;

    // Signed compare directly, so an overflowing A - B cannot flip the answer.
    assign lt_signed = $signed(A) < $signed(B);

    always_comb begin
        result_d = '0;
        unique case (Operation)
            OP_AND: result_d = A & B;
            OP_OR:  result_d = A | B;
            OP_ADD: result_d = A + B;
            OP_XOR: result_d = A ^ B;
            OP_NOR: result_d = ~(A | B);
            OP_SLL: result_d = A << B[4:0];
            OP_SUB: result_d = A - B;
            OP_SLT: result_d = {31'd0, lt_signed};
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) result_q <= '0;
        else       result_q <= result_d;
    end

    assign Output = result_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: reset, each opcode, wrap/shift/SLT corners,
// back-to-back opcodes and between-edge input glitches.
module tb_alu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [2:0]  Operation = '0;
    logic [31:0] Output;

    int total = 0;
    int bad = 0;

    alu dut (
        .clk(clk),
        .reset(reset),
        .A(A),
        .B(B),
        .Operation(Operation),
        .Output(Output)
    );

    always #5 clk = ~clk;

    // Drive on the falling edge, then sample 1ns after the capturing rising edge.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        @(negedge clk);
        A = a; B = b; Operation = op;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        drive(32'd7, 32'd9, 3'b001);
        reset = 1'b0;
        // Mid-cycle assert, no clock edge: must clear immediately.
        @(negedge clk);
        A = 32'd5; B = 32'd3; Operation = 3'b010;
        #1 reset = 1'b1;
        #1;
        total++;
        if (Output !== 32'h0) begin
            bad++; $display("FAIL reset_async got=%h want=%h", Output, 32'h0);
        end
        @(posedge clk); #1;
        total++;
        if (Output !== 32'h0) begin
            bad++; $display("FAIL reset_hold got=%h want=%h", Output, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        total++;
        if (Output !== 32'd8) begin
            bad++; $display("FAIL reset_release got=%h want=%h", Output, 32'd8);
        end
    endtask

    task automatic test_logic;
        logic [2:0]  ops [4] = '{3'b000, 3'b001, 3'b011, 3'b100};
        logic [31:0] exp [4] = '{32'h00F0_000F, 32'hFFF0_0FFF, 32'hFF00_0FF0, 32'h000F_F000};
        for (int i = 0; i < 4; i++) begin
            drive(32'hF0F0_00FF, 32'h0FF0_0F0F, ops[i]);
            total++;
            if (Output !== exp[i]) begin
                bad++; $display("FAIL logic_op%0d got=%h want=%h", ops[i], Output, exp[i]);
            end
        end
    endtask

    task automatic test_arith;
        logic [31:0] av [4] = '{32'hFFFF_FFFF, 32'd0, 32'd10, 32'h7FFF_FFFF};
        logic [31:0] bv [4] = '{32'd1, 32'd1, 32'd3, 32'd1};
        logic [2:0]  op [4] = '{3'b010, 3'b110, 3'b110, 3'b010};
        logic [31:0] ex [4] = '{32'h0, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000};
        for (int i = 0; i < 4; i++) begin
            drive(av[i], bv[i], op[i]);
            total++;
            if (Output !== ex[i]) begin
                bad++; $display("FAIL arith_%0d got=%h want=%h", i, Output, ex[i]);
            end
        end
    endtask

    task automatic test_shift;
        logic [31:0] av [3] = '{32'd1, 32'h0000_00FF, 32'hFFFF_FFFF};
        logic [31:0] bv [3] = '{32'd31, 32'hFFFF_FFE4, 32'd32};
        logic [31:0] ex [3] = '{32'h8000_0000, 32'h0000_0FF0, 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            drive(av[i], bv[i], 3'b101);
            total++;
            if (Output !== ex[i]) begin
                bad++; $display("FAIL sll_%0d got=%h want=%h", i, Output, ex[i]);
            end
        end
    endtask

    task automatic test_slt;
        logic [31:0] av [6] = '{32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1234, 32'd3};
        logic [31:0] bv [6] = '{32'd1, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'd1234, 32'd4};
        logic [31:0] ex [6] = '{32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1};
        for (int i = 0; i < 6; i++) begin
            drive(av[i], bv[i], 3'b111);
            total++;
            if (Output !== ex[i]) begin
                bad++; $display("FAIL slt_%0d got=%h want=%h", i, Output, ex[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ex [8] = '{32'd8, 32'd14, 32'd22, 32'd6, 32'hFFFF_FFF1, 32'd12288, 32'd2, 32'd0};
        for (int i = 0; i < 8; i++) begin
            drive(32'd12, 32'd10, 3'(i));
            total++;
            if (Output !== ex[i]) begin
                bad++; $display("FAIL b2b_op%0d got=%h want=%h", i, Output, ex[i]);
            end
        end
    endtask

    task automatic test_glitch;
        drive(32'd12, 32'd10, 3'b010);
        for (int g = 0; g < 3; g++) begin
            #1 A = 32'hDEAD_0000 + 32'(g);
            #1;
            total++;
            if (Output !== 32'd22) begin
                bad++; $display("FAIL glitch_hold%0d got=%h want=%h", g, Output, 32'd22);
            end
        end
        @(negedge clk);
        A = 32'd100;
        @(posedge clk); #1;
        total++;
        if (Output !== 32'd110) begin
            bad++; $display("FAIL glitch_capture got=%h want=%h", Output, 32'd110);
        end
    endtask

    initial begin
        reset = 1'b1;
        #12;
        reset = 1'b0;
        test_reset();
        test_logic();
        test_arith();
        test_shift();
        test_slt();
        test_back_to_back();
        test_glitch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
